// File: rtl/ssd_pkg.sv
// Shared constants and types for the score seven-segment scanner.
// Segment patterns are {dp,g,f,e,d,c,b,a}, active-low.
package ssd_pkg;

  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [7:0] AN_OFF   = 8'hFF;

  localparam logic [2:0] IDX_ONES  = 3'd0;
  localparam logic [2:0] IDX_TENS  = 3'd1;
  localparam logic [2:0] IDX_LIVES = 3'd3;

  typedef struct packed {
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] lives;
  } shadow_t;

endpackage

// File: rtl/score_ssd_scanner_if.sv
// Score/lives inputs and display outputs of the seven-segment scanner.
// The game side (master) drives the values; the scanner (slave) drives the display.
interface score_ssd_scanner_if;

  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic [3:0] lives;
  logic       blank;
  logic [7:0] an;
  logic [7:0] ssd;
  logic       frame_done;

  modport master (
    output score_ones, score_tens, lives, blank,
    input  an, ssd, frame_done
  );

  modport slave (
    input  score_ones, score_tens, lives, blank,
    output an, ssd, frame_done
  );

endinterface

// File: rtl/bcd_to_ssd.sv
// Combinational 4-bit value to active-low seven-segment pattern; 10..15 show a dash.
module bcd_to_ssd
  import ssd_pkg::*;
(
  input  logic [3:0] val,
  output logic [7:0] seg
);

  always_comb begin
    case (val)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_ssd_scanner.sv
// 8-digit multiplexed seven-segment scanner for score (ones/tens) and lives, snapshotted once per frame.
// Optional lives-digit blinking when lives==1 is enabled with `define SSD_BLINK_EN.
module score_ssd_scanner
  import ssd_pkg::*;
#(
  parameter int unsigned DIGIT_PERIOD = 100_000,
  parameter bit          LZB          = 1'b1,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                rst,
  score_ssd_scanner_if.slave  bus
);

  localparam int unsigned DIV_W = $clog2(DIGIT_PERIOD);

  if (DIGIT_PERIOD < 2 || BLINK_FRAMES < 1) begin : g_bad_params
    $error("score_ssd_scanner: DIGIT_PERIOD must be >= 2 and BLINK_FRAMES >= 1");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       idx_q, idx_d;
  shadow_t          shadow_q, shadow_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       ssd_q, ssd_d;
  logic             frame_done_q, frame_done_d;

  logic             tick;
  logic             frame_tick;
  logic             lives_dark;
  logic             lit;
  logic [3:0]       digit_val;
  logic [7:0]       digit_seg;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tick       = (div_cnt_q == DIV_W'(DIGIT_PERIOD - 1));
    frame_tick = tick && (idx_q == 3'd7);

    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
    idx_d      = tick ? idx_q + 3'd1 : idx_q;

    shadow_d   = shadow_q;
    if (frame_tick) begin
      shadow_d.ones  = bus.score_ones;
      shadow_d.tens  = bus.score_tens;
      shadow_d.lives = bus.lives;
    end
    frame_done_d = frame_tick;
  end

`ifdef SSD_BLINK_EN
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
  logic             blink_ph_q, blink_ph_d;

  always_comb begin
    frm_cnt_d  = frm_cnt_q;
    blink_ph_d = blink_ph_q;
    if (frame_tick) begin
      if (frm_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frm_cnt_d  = '0;
        blink_ph_d = ~blink_ph_q;
      end else begin
        frm_cnt_d  = frm_cnt_q + FRM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frm_cnt_q  <= '0;
      blink_ph_q <= 1'b0;
    end else begin
      frm_cnt_q  <= frm_cnt_d;
      blink_ph_q <= blink_ph_d;
    end
  end

  assign lives_dark = blink_ph_q && (shadow_q.lives == 4'd1);
`else
  assign lives_dark = 1'b0;
`endif

  // Slot map: choose the digit for the current idx and whether its anode lights.
  always_comb begin
    digit_val = shadow_q.ones;
    lit       = 1'b0;
    case (idx_q)
      IDX_ONES: begin
        digit_val = shadow_q.ones;
        lit       = 1'b1;
      end
      IDX_TENS: begin
        digit_val = shadow_q.tens;
        lit       = !(LZB && (shadow_q.tens == 4'd0));
      end
      IDX_LIVES: begin
        digit_val = shadow_q.lives;
        lit       = !lives_dark;
      end
      default: ;
    endcase
  end

  bcd_to_ssd u_dec (
    .val (digit_val),
    .seg (digit_seg)
  );

  always_comb begin
    an_d  = AN_OFF;
    ssd_d = SEG_OFF;
    if (lit && !bus.blank) begin
      an_d  = ~(8'b1 << idx_q);
      ssd_d = digit_seg;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the shadow registers are reset too, so a mid-frame reset never leaves a stale score on display.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      an_q         <= AN_OFF;
      ssd_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      ssd_q        <= ssd_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.ssd        = ssd_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_score_ssd_scanner.sv
// Self-checking bench for score_ssd_scanner: table vectors, corner sequences and random stimulus
// against a frame-arithmetic reference model. Blink checks are active when SSD_BLINK_EN is defined.
module tb_score_ssd_scanner;

  localparam int DP    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 8 * DP;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_ssd_scanner_if bus ();

  score_ssd_scanner #(
    .DIGIT_PERIOD (DP),
    .LZB          (1'b1),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: m_n counts clock edges since reset; slot and snapshots follow from it.
  int         m_n;
  int         m_snaps;
  logic [3:0] m_ones, m_tens, m_lives;
  logic [7:0] exp_an, exp_ssd;
  logic       exp_fd;
  logic [7:0] seg_tab [16];

  typedef struct {
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] lives;
    int         slot;
    logic [7:0] an;
    logic [7:0] ssd;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_out(input logic blank_in, output logic [7:0] a, output logic [7:0] s);
    int         slot;
    bit         lit;
    logic [3:0] v;
    slot = (m_n / DP) % 8;
    lit  = 1'b0;
    v    = 4'd0;
    if (slot == 0) begin
      v   = m_ones;
      lit = 1'b1;
    end else if (slot == 1) begin
      v   = m_tens;
      lit = (m_tens != 4'd0);
    end else if (slot == 3) begin
      v   = m_lives;
      lit = 1'b1;
`ifdef SSD_BLINK_EN
      if (m_lives == 4'd1 && ((m_snaps / BF) % 2 == 1)) lit = 1'b0;
`endif
    end
    if (blank_in) lit = 1'b0;
    a = lit ? ~(8'd1 << slot) : 8'hFF;
    s = lit ? seg_tab[v] : 8'hFF;
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare all outputs.
  task automatic step();
    logic [7:0] a, s;
    @(posedge clk);
    if (rst) begin
      m_n = 0; m_snaps = 0;
      m_ones = 4'd0; m_tens = 4'd0; m_lives = 4'd0;
      exp_an = 8'hFF; exp_ssd = 8'hFF; exp_fd = 1'b0;
    end else begin
      model_out(bus.blank, a, s);
      exp_an  = a;
      exp_ssd = s;
      m_n++;
      exp_fd = (m_n % FRAME == 0);
      if (exp_fd) begin
        m_ones  = bus.score_ones;
        m_tens  = bus.score_tens;
        m_lives = bus.lives;
        m_snaps++;
      end
    end
    #1;
    check("an", bus.an, exp_an);
    check("ssd", bus.ssd, exp_ssd);
    check("frame_done", bus.frame_done, exp_fd);
  endtask

  task automatic run_to_snapshot();
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      if (exp_fd) break;
    end
  endtask

  function automatic int shown_slot();
    return ((m_n - 1) / DP) % 8;
  endfunction

  task automatic run_to_slot(input int s);
    for (int k = 0; k < 2 * FRAME; k++) begin
      step();
      if (shown_slot() == s) break;
    end
  endtask

  task automatic set_in(input logic [3:0] o, input logic [3:0] t, input logic [3:0] l);
    bus.score_ones = o;
    bus.score_tens = t;
    bus.lives      = l;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

    vecs.push_back('{4'd7,  4'd2, 4'd3,  0, 8'hFE, 8'hF8});
    vecs.push_back('{4'd7,  4'd2, 4'd3,  1, 8'hFD, 8'hA4});
    vecs.push_back('{4'd7,  4'd2, 4'd3,  3, 8'hF7, 8'hB0});
    vecs.push_back('{4'd7,  4'd2, 4'd3,  2, 8'hFF, 8'hFF});
    vecs.push_back('{4'd7,  4'd2, 4'd3,  6, 8'hFF, 8'hFF});
    vecs.push_back('{4'd5,  4'd0, 4'd3,  1, 8'hFF, 8'hFF});
    vecs.push_back('{4'd5,  4'd0, 4'd3,  0, 8'hFE, 8'h92});
    vecs.push_back('{4'd4,  4'd9, 4'hA,  3, 8'hF7, 8'hBF});
    vecs.push_back('{4'd4,  4'd9, 4'hA,  0, 8'hFE, 8'h99});
    vecs.push_back('{4'd4,  4'd9, 4'hA,  1, 8'hFD, 8'h90});
    vecs.push_back('{4'hF,  4'd8, 4'd6,  0, 8'hFE, 8'hBF});
    vecs.push_back('{4'hF,  4'd8, 4'd6,  1, 8'hFD, 8'h80});
    vecs.push_back('{4'hF,  4'd8, 4'd6,  3, 8'hF7, 8'h82});
    vecs.push_back('{4'd0,  4'hC, 4'd2,  1, 8'hFD, 8'hBF});

    // Reset
    set_in(4'd0, 4'd0, 4'd0);
    bus.blank = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("reset_an", bus.an, 8'hFF);
    check("reset_ssd", bus.ssd, 8'hFF);
    check("reset_fd", bus.frame_done, 1'b0);
    rst = 1'b0;
    step();
    check("post_reset_an", bus.an, 8'hFE);
    check("post_reset_ssd", bus.ssd, 8'hC0);

    // Table-driven slot vectors: hold inputs through a snapshot, then view one slot.
    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].ones, vecs[i].tens, vecs[i].lives);
      run_to_snapshot();
      run_to_slot(vecs[i].slot);
      check($sformatf("vec%0d_an", i), bus.an, vecs[i].an);
      check($sformatf("vec%0d_ssd", i), bus.ssd, vecs[i].ssd);
    end

    // Snapshot hold: ones changes while its slot is lit; display keeps the old value.
    set_in(4'd1, 4'd3, 4'd3);
    run_to_snapshot();
    step();
    bus.score_ones = 4'd2;
    for (int i = 0; i < DP - 1; i++) begin
      step();
      check("snap_hold_ones", bus.ssd, 8'hF9);
    end
    run_to_slot(2);
    bus.score_ones = 4'd1;
    run_to_slot(7);
    bus.score_ones = 4'd2;
    run_to_snapshot();
    step();
    check("snap_new_ones", bus.ssd, 8'hA4);

    // Input change on the snapshot edge is captured; one cycle later is not.
    for (int k = 0; k < FRAME; k++) begin
      if (m_n % FRAME == FRAME - 1) break;
      step();
    end
    bus.lives = 4'd9;
    step();
    check("tick_fd", bus.frame_done, 1'b1);
    bus.lives = 4'd4;
    run_to_slot(3);
    check("tick_capture", bus.ssd, 8'h90);
    run_to_snapshot();
    run_to_slot(3);
    check("late_capture", bus.ssd, 8'h99);

    // Blank mid-slot, then release.
    run_to_slot(0);
    step();
    bus.blank = 1'b1;
    step();
    check("blank_an", bus.an, 8'hFF);
    for (int i = 0; i < 10; i++) step();
    bus.blank = 1'b0;
    run_to_slot(3);
    check("unblank_an", bus.an, 8'hF7);

    // Mid-frame reset clears the shadow.
    set_in(4'd7, 4'd2, 4'd3);
    run_to_snapshot();
    run_to_slot(3);
    step();
    rst = 1'b1;
    step();
    check("midrst_an", bus.an, 8'hFF);
    check("midrst_ssd", bus.ssd, 8'hFF);
    rst = 1'b0;
    step();
    check("midrst_release_an", bus.an, 8'hFE);
    check("midrst_release_ssd", bus.ssd, 8'hC0);
    run_to_slot(3);
    check("midrst_lives_shadow", bus.ssd, 8'hC0);

    // Lives other than 1 is always steady.
    set_in(4'd0, 4'd0, 4'd2);
    for (int f = 0; f < 4; f++) begin
      run_to_snapshot();
      run_to_slot(3);
      check("steady_lives", bus.an, 8'hF7);
    end

`ifdef SSD_BLINK_EN
    // lives==1 blinks with a BF-frame half period; compared against frame arithmetic.
    bus.lives = 4'd1;
    for (int f = 0; f < 8; f++) begin
      run_to_snapshot();
      run_to_slot(3);
      check("blink_an", bus.an, ((m_snaps / BF) % 2 == 1) ? 8'hFF : 8'hF7);
    end
`endif

    // Random stimulus against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(3) == 0)
        set_in(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(4)));
      if ($urandom_range(15) == 0) bus.blank = ~bus.blank;
      step();
    end
    bus.blank = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
